mdu_e: RTL
==========

MDU_E -- requirements
Module: mdu_e

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: busy duration of multiply-class ops, in cycles.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: busy duration of divide-class ops, in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU op; sampled on posedge.
REQ-006 SHALL have port mdop_E  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 treated as none.
REQ-007 SHALL have port rsval_E  input  32  forwarded GPR[rs] operand.
REQ-008 SHALL have port rtval_E  input  32  forwarded GPR[rt] operand.
REQ-009 SHALL have port busy_E  output  1  high while an op is in flight.
REQ-010 SHALL have port registerhi_E  output  32  architectural HI, feeding the E/M flow register.
REQ-011 SHALL have port registerlo_E  output  32  architectural LO, feeding the E/M flow register.

Function
REQ-012 SHALL latch rsval_E, rtval_E and mdop_E at the posedge where start=1, busy_E=0 and op is 1-4 (or 7-10 when enabled per REQ-027).
REQ-013 SHALL load the internal counter with MULT_CYCLES (ops 1,2,7-10) or DIV_CYCLES (ops 3,4) at that edge; busy_E goes to 1 from the next cycle.
REQ-014 SHALL decrement the counter on each posedge while busy; the edge taking it from 1 to 0 writes HI/LO and clears busy_E, so busy_E stays high for exactly N cycles.
REQ-015 SHALL keep registerhi_E/registerlo_E at their old values throughout busy; new values become visible in the first cycle after busy_E falls.
REQ-016 SHALL produce mult as the signed 64-bit product and multu as the unsigned one, HI = [63:32], LO = [31:0].
REQ-017 SHALL produce div/divu as LO = quotient and HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-018 SHALL, for signed 0x80000000 / 0xFFFFFFFF, give LO = 0x80000000 and HI = 0.
REQ-019 SHALL, on divide by zero, leave HI and LO unchanged at completion, with busy_E still lasting DIV_CYCLES.
REQ-020 SHALL execute mthi/mtlo in one cycle with no busy: HI (or LO) = rsval_E at the sampling edge, when busy_E=0.
REQ-021 SHALL ignore start while busy_E=1; the hazard unit guarantees none, but the in-flight op must complete uncorrupted.
REQ-022 SHALL treat op 0 or 11-15 with start=1 as a no-op.
REQ-023 SHALL compute all arithmetic at 64-bit width, with unsigned ops zero-extended and signed ops sign-extended.

Reset
REQ-024 SHALL, at a posedge with reset=1, set busy_E=0, counter=0, registerhi_E=0 and registerlo_E=0, and clear the latched operands/op.
REQ-025 SHALL, on reset mid-operation, discard the pending result; HI/LO read 0 the next cycle and no later write occurs.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL support macro MDU_MADD_EN: when defined, ops 7-10 accumulate {HI,LO} +/- product (signed for madd/msub, unsigned for maddu/msubu), mod 2^64, written at completion.
REQ-028 SHALL, without MDU_MADD_EN, treat ops 7-10 as no-ops: no busy, no HI/LO change.

Verification
REQ-029 SHALL cover mult 0xFFFFFFFF x 0x00000002 -> busy_E high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE (multu gives HI=0x00000001, LO=0xFFFFFFFE).
REQ-030 SHALL cover div -7 / 2 -> busy_E 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-031 SHALL cover mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge after each, busy_E never asserted.
REQ-032 SHALL cover mult in flight plus start=1 with mtlo on cycle 2 -> mtlo ignored; LO equals the product at completion.
REQ-033 SHALL cover reset asserted on cycle 3 of a div -> next cycle busy_E=0, HI=LO=0, and no write afterwards.
REQ-034 SHALL cover, with MDU_MADD_EN, HI=0, LO=0xFFFFFFFF then maddu 1x1 -> HI=1, LO=0; without the macro -> HI/LO unchanged and busy_E=0.

Source files
------------

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit with architectural HI/LO registers.
// Multiply-class ops stay busy for MULT_CYCLES, divide-class ops for
// DIV_CYCLES; HI/LO are written on the last busy edge. mthi/mtlo complete
// in a single cycle without raising busy_E.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu, which
// accumulate into {HI,LO}. Without it those op codes are no-ops.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop_E,
  input  logic [31:0] rsval_E,
  input  logic [31:0] rtval_E,
  output logic        busy_E,
  output logic [31:0] registerhi_E,
  output logic [31:0] registerlo_E
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          load_s;
  logic          finish_s;

  logic [3:0]    op_r;
  logic [31:0]   a_r;
  logic [31:0]   b_r;

  logic [63:0]   a64s_s, b64s_s, a64u_s, b64u_s;
  logic [63:0]   b64s_nz_s, b64u_nz_s;
  logic [63:0]   sprod_s, uprod_s;
  logic [31:0]   squo_s, srem_s, uquo_s, urem_s;
  logic          div_zero_s;
  logic [31:0]   res_hi_s, res_lo_s;
  logic          res_wr_s;
`ifdef MDU_MADD_EN
  logic [63:0]   acc_s;
`endif

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic op_is_long(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  assign busy_E = (state_r == S_BUSY);

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: accept a long op when idle, count down while busy.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && op_is_long(mdop_E)) begin
          state_s = S_BUSY;
          cnt_s   = op_is_div(mdop_E) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if ((cnt_r == CW'(1)) || (cnt_r == {CW{1'b0}})) begin
          state_s  = S_IDLE;
          cnt_s    = {CW{1'b0}};
          finish_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // 64-bit operand views; a zero divisor is replaced so the dividers never see 0.
  assign a64s_s     = {{32{a_r[31]}}, a_r};
  assign b64s_s     = {{32{b_r[31]}}, b_r};
  assign a64u_s     = {32'd0, a_r};
  assign b64u_s     = {32'd0, b_r};
  assign div_zero_s = (b_r == 32'd0);
  assign b64s_nz_s  = div_zero_s ? 64'd1 : b64s_s;
  assign b64u_nz_s  = div_zero_s ? 64'd1 : b64u_s;

  // Low 64 bits of a sign-extended product equal the true signed product.
  assign sprod_s = a64s_s * b64s_s;
  assign uprod_s = a64u_s * b64u_s;
  // Dividing at 64 bits makes 0x80000000 / -1 yield 2^31, whose low word is 0x80000000.
  assign squo_s  = 32'($signed(a64s_s) / $signed(b64s_nz_s));
  assign srem_s  = 32'($signed(a64s_s) % $signed(b64s_nz_s));
  assign uquo_s  = 32'(a64u_s / b64u_nz_s);
  assign urem_s  = 32'(a64u_s % b64u_nz_s);
`ifdef MDU_MADD_EN
  assign acc_s   = {registerhi_E, registerlo_E};
`endif

  // Select the completion result for the latched op.
  always_comb begin
    res_hi_s = registerhi_E;
    res_lo_s = registerlo_E;
    res_wr_s = 1'b0;
    case (op_r)
      OP_MULT: begin
        {res_hi_s, res_lo_s} = sprod_s;
        res_wr_s = 1'b1;
      end
      OP_MULTU: begin
        {res_hi_s, res_lo_s} = uprod_s;
        res_wr_s = 1'b1;
      end
      OP_DIV: begin
        res_hi_s = srem_s;
        res_lo_s = squo_s;
        res_wr_s = !div_zero_s;
      end
      OP_DIVU: begin
        res_hi_s = urem_s;
        res_lo_s = uquo_s;
        res_wr_s = !div_zero_s;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        {res_hi_s, res_lo_s} = acc_s + sprod_s;
        res_wr_s = 1'b1;
      end
      OP_MADDU: begin
        {res_hi_s, res_lo_s} = acc_s + uprod_s;
        res_wr_s = 1'b1;
      end
      OP_MSUB: begin
        {res_hi_s, res_lo_s} = acc_s - sprod_s;
        res_wr_s = 1'b1;
      end
      OP_MSUBU: begin
        {res_hi_s, res_lo_s} = acc_s - uprod_s;
        res_wr_s = 1'b1;
      end
`endif
      default: begin
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Operand latch and HI/LO update (completion write or single-cycle mthi/mtlo).
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r         <= 4'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      registerhi_E <= 32'd0;
      registerlo_E <= 32'd0;
    end else begin
      if (load_s) begin
        op_r <= mdop_E;
        a_r  <= rsval_E;
        b_r  <= rtval_E;
      end
      if (finish_s) begin
        if (res_wr_s) begin
          registerhi_E <= res_hi_s;
          registerlo_E <= res_lo_s;
        end
      end else if ((state_r == S_IDLE) && start) begin
        case (mdop_E)
          OP_MTHI: registerhi_E <= rsval_E;
          OP_MTLO: registerlo_E <= rsval_E;
          default: ;
        endcase
      end
    end
  end

endmodule
